// File: rtl/gdu_pkg.sv
// Shared graphics-datapath definitions: raster geometry, fetch burst shape,
// pixel type and the scanout fetch state encoding.
package gdu_pkg;

  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;
  localparam int unsigned FRAME_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int unsigned BURST_LEN   = 16;
  localparam int unsigned FIFO_DEPTH  = 64;

  localparam int unsigned BURST_CNT_W = 15;
  localparam int unsigned POP_CNT_W   = 19;
  localparam int unsigned BEAT_CNT_W  = 5;

  typedef logic [23:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CHECK,
    ST_REQ,
    ST_RECV,
    ST_FULL_FRAME,
    ST_DRAIN
  } scan_state_e;

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous show-ahead FIFO; dout presents the head word whenever non-empty.
// Flush has priority over push and pop.
module scanout_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; contents are only visible once written
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/frame_scanout.sv
// Framebuffer scanout: bursts the current frame out of SDRAM into a pixel FIFO
// and hands one pixel per request to the VGA stage; rebases at every frame start.
module frame_scanout #(
  parameter int unsigned H_ACTIVE   = gdu_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = gdu_pkg::V_ACTIVE,
  parameter int unsigned BURST_LEN  = gdu_pkg::BURST_LEN,
  parameter int unsigned FIFO_DEPTH = gdu_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] frame_base,
  input  logic        frame_start,
  output logic [31:0] avm_address,
  output logic [4:0]  avm_burstcount,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest,
  input  logic        pix_req,
  output logic [23:0] pix_data,
  output logic        underflow,
  output logic        frame_done
);
  import gdu_pkg::*;

  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int unsigned BURSTS    = FRAME_PIX / BURST_LEN;
  localparam int unsigned STRIDE    = BURST_LEN * 4;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

  if (FRAME_PIX % BURST_LEN != 0) begin : g_chk_div
    $error("frame_scanout: frame size is not a whole number of bursts");
  end
  if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_chk_burst
    $error("frame_scanout: BURST_LEN must be 1..16");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * BURST_LEN) begin : g_chk_fifo
    $error("frame_scanout: FIFO_DEPTH must be a power of two >= 2*BURST_LEN");
  end
  if (BURSTS >= (1 << BURST_CNT_W) || FRAME_PIX > (1 << POP_CNT_W)) begin : g_chk_cnt
    $error("frame_scanout: frame too large for the fetch/pop counters");
  end

  scan_state_e              state_q;
  logic [31:0]              base_q;
  logic [BURST_CNT_W-1:0]   burst_cnt_q;
  logic [BEAT_CNT_W-1:0]    beat_cnt_q;
  logic                     drain_q;
  logic                     read_q;
  logic [31:0]              addr_q;
  logic [4:0]               bcount_q;
  logic [POP_CNT_W-1:0]     pop_cnt_q;
  logic                     over_q;
  pixel_t                   pix_q;
  logic                     underflow_q;
  logic                     done_q;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_flush;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [CNT_W-1:0]         fifo_count;
  pixel_t                   fifo_dout;
  logic                     frame_clr;
  logic                     last_beat;
  logic                     space_ok;
  logic                     unused_rd_hi;

  assign avm_read       = read_q;
  assign avm_address    = addr_q;
  assign avm_burstcount = bcount_q;
  assign pix_data       = pix_q;
  assign underflow      = underflow_q;
  assign frame_done     = done_q;
  assign unused_rd_hi   = ^avm_readdata[31:24];

  // A frame start wins over everything on the pixel side and empties the FIFO
  assign frame_clr  = frame_start || (state_q == ST_START);
  assign fifo_flush = frame_clr;
  assign fifo_push  = avm_readdatavalid && (state_q == ST_RECV);
  assign fifo_pop   = pix_req && !fifo_empty && !over_q && !frame_clr;
  assign last_beat  = avm_readdatavalid && (beat_cnt_q == BEAT_CNT_W'(BURST_LEN - 1));
  assign space_ok   = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(BURST_LEN);

  scanout_fifo #(
    .WIDTH ($bits(pixel_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (avm_readdata[23:0]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Fetch FSM: one outstanding burst, issued only when a whole burst fits
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      burst_cnt_q <= '0;
      beat_cnt_q  <= '0;
      drain_q     <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      bcount_q    <= '0;
    end else begin
      if (frame_start) base_q <= frame_base;
      unique case (state_q)
        ST_IDLE, ST_FULL_FRAME: begin
          if (frame_start) state_q <= ST_START;
        end
        ST_START: begin
          burst_cnt_q <= '0;
          beat_cnt_q  <= '0;
          drain_q     <= 1'b0;
          if (!frame_start) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (frame_start) begin
            state_q <= ST_START;
          end else if (burst_cnt_q == BURST_CNT_W'(BURSTS)) begin
            state_q <= ST_FULL_FRAME;
          end else if (space_ok) begin
            read_q   <= 1'b1;
            addr_q   <= base_q + 32'(burst_cnt_q) * 32'(STRIDE);
            bcount_q <= 5'(BURST_LEN);
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A pending request cannot be withdrawn; remember the restart instead
          if (!avm_waitrequest) begin
            read_q     <= 1'b0;
            bcount_q   <= '0;
            beat_cnt_q <= '0;
            drain_q    <= 1'b0;
            state_q    <= (drain_q || frame_start) ? ST_DRAIN : ST_RECV;
          end else if (frame_start) begin
            drain_q <= 1'b1;
          end
        end
        ST_RECV: begin
          if (avm_readdatavalid) beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
          if (last_beat) begin
            burst_cnt_q <= burst_cnt_q + BURST_CNT_W'(1);
            state_q     <= frame_start ? ST_START : ST_CHECK;
          end else if (frame_start) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (avm_readdatavalid) beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
          if (last_beat) state_q <= ST_START;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pixel side: every request in the frame advances the raster, data or not
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q       <= '0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
      pop_cnt_q   <= '0;
      over_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (frame_clr) begin
        pop_cnt_q   <= '0;
        underflow_q <= 1'b0;
        over_q      <= 1'b0;
      end else if (pix_req) begin
        if (over_q) begin
          pix_q <= '0;
        end else begin
          if (fifo_empty) begin
            pix_q       <= '0;
            underflow_q <= 1'b1;
          end else begin
            pix_q <= fifo_dout;
          end
          if (pop_cnt_q == POP_CNT_W'(FRAME_PIX - 1)) begin
            done_q <= 1'b1;
            over_q <= 1'b1;
          end else begin
            pop_cnt_q <= pop_cnt_q + POP_CNT_W'(1);
          end
        end
      end
    end
  end

  // Free-space gating in CHECK must make an overflowing push impossible
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(fifo_push && fifo_full && !fifo_pop && !fifo_flush));
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout on a reduced 32x8 raster with an Avalon
// burst slave model returning word (addr/4 + 0x123) in the low 24 bits.
module tb_frame_scanout;
  import gdu_pkg::*;

  localparam int unsigned H     = 32;
  localparam int unsigned V     = 8;
  localparam int unsigned BL    = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned FRAME = H * V;

  logic        clk;
  logic        reset;
  logic [31:0] frame_base;
  logic        frame_start;
  logic [31:0] avm_address;
  logic [4:0]  avm_burstcount;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
  logic        pix_req;
  logic [23:0] pix_data;
  logic        underflow;
  logic        frame_done;

  int          vectors = 0;
  int          errors  = 0;

  int          accepts = 0;
  logic [31:0] acc_log [$];
  logic [31:0] acc_a;
  logic [4:0]  last_bc;
  int          rsp_gap = 0;
  int          pause_beat = -1;
  int          pause_cycles = 0;

  frame_scanout #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .BURST_LEN  (BL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .frame_base        (frame_base),
    .frame_start       (frame_start),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_read          (avm_read),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .pix_req           (pix_req),
    .pix_data          (pix_data),
    .underflow         (underflow),
    .frame_done        (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {8'hEE, 24'((a >> 2) + 32'h123)};
  endfunction

  function automatic logic [23:0] exp_pix(input logic [31:0] b, input int unsigned i);
    return 24'((b >> 2) + 32'(i) + 32'h123);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] b);
    frame_base  = b;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Avalon slave: one burst at a time, beats start the cycle after accept
  initial begin
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clk);
      if (!reset && avm_read && !avm_waitrequest) begin
        acc_a   = avm_address;
        last_bc = avm_burstcount;
        accepts++;
        acc_log.push_back(acc_a);
        @(negedge clk);
        repeat (rsp_gap) @(negedge clk);
        for (int b = 0; b < int'(BL); b++) begin
          if (b == pause_beat) begin
            avm_readdatavalid = 1'b0;
            repeat (pause_cycles) @(negedge clk);
          end
          avm_readdatavalid = 1'b1;
          avm_readdata      = word_at(acc_a + 32'(b * 4));
          @(negedge clk);
        end
        avm_readdatavalid = 1'b0;
      end
    end
  end

  initial begin
    int n;
    int a0;
    reset           = 1'b1;
    frame_base      = '0;
    frame_start     = 1'b0;
    avm_waitrequest = 1'b0;
    pix_req         = 1'b0;
    tick(3);

    check("rst_read",       32'(avm_read),       32'd0);
    check("rst_address",    avm_address,         32'd0);
    check("rst_burstcount", 32'(avm_burstcount), 32'd0);
    check("rst_pix_data",   32'(pix_data),       32'd0);
    check("rst_underflow",  32'(underflow),      32'd0);
    check("rst_frame_done", 32'(frame_done),     32'd0);
    reset = 1'b0;
    tick(5);
    check("idle_no_read",   32'(accepts),        32'd0);

    // Fetch start: four bursts fill the 64-word FIFO, then fetch pauses
    pulse_start(32'h0010_0000);
    tick(150);
    check("t1_accepts",     32'(accepts),          32'd4);
    check("t1_addr0",       acc_log[0],            32'h0010_0000);
    check("t1_addr1",       acc_log[1],            32'h0010_0040);
    check("t1_addr3",       acc_log[3],            32'h0010_00C0);
    check("t1_burstcount",  32'(last_bc),          32'd16);
    check("t1_fifo_full",   32'(dut.fifo_count),   32'd64);
    check("t1_read_idle",   32'(avm_read),         32'd0);

    // Full-frame scanout, one request every fourth cycle
    for (int i = 0; i < int'(FRAME); i++) begin
      pix_req = 1'b1;
      @(negedge clk);
      pix_req = 1'b0;
      check("t3_pix", 32'(pix_data), 32'(exp_pix(32'h0010_0000, i)));
      check("t3_done", 32'(frame_done), (i == int'(FRAME) - 1) ? 32'd1 : 32'd0);
      tick(3);
    end
    check("t3_underflow",   32'(underflow),        32'd0);
    check("t3_accepts",     32'(accepts),          32'd16);
    check("t3_last_addr",   acc_log[15],           32'h0010_03C0);
    pix_req = 1'b1;
    @(negedge clk);
    pix_req = 1'b0;
    check("t3_past_pix",    32'(pix_data),         32'd0);
    check("t3_past_uflow",  32'(underflow),        32'd0);
    check("t3_past_done",   32'(frame_done),       32'd0);

    // Waitrequest stall holds the request stable
    a0 = accepts;
    avm_waitrequest = 1'b1;
    pulse_start(32'h0030_0000);
    n = 0;
    while (avm_read !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    check("t2_read_seen", 32'(avm_read), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_read", 32'(avm_read),       32'd1);
      check("t2_hold_addr", avm_address,         32'h0030_0000);
      check("t2_hold_bc",   32'(avm_burstcount), 32'd16);
      tick(1);
    end
    check("t2_no_accept", 32'(accepts), 32'(a0));
    avm_waitrequest = 1'b0;
    tick(1);
    avm_waitrequest = 1'b1;
    check("t2_read_drop",  32'(avm_read),        32'd0);
    check("t2_one_accept", 32'(accepts),         32'(a0 + 1));
    tick(30);
    check("t2_pushes",     32'(dut.fifo_count),  32'd16);
    check("t2_accepts",    32'(accepts),         32'(a0 + 1));
    check("t6_pre_read",   32'(avm_read),        32'd1);
    check("t6_pre_addr",   avm_address,          32'h0030_0040);

    // Reset while a request is stalled
    reset = 1'b1;
    tick(1);
    check("t6_read",       32'(avm_read),        32'd0);
    check("t6_address",    avm_address,          32'd0);
    check("t6_burstcount", 32'(avm_burstcount),  32'd0);
    check("t6_underflow",  32'(underflow),       32'd0);
    check("t6_state",      32'(dut.state_q),     32'(ST_IDLE));
    check("t6_fifo_empty", 32'(dut.fifo_count),  32'd0);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    tick(20);
    check("t6_no_read",    32'(accepts),         32'(a0 + 1));
    check("t6_read_low",   32'(avm_read),        32'd0);

    // Restart mid-burst: the rest of the burst is discarded
    a0 = accepts;
    pause_beat   = 7;
    pause_cycles = 6;
    pulse_start(32'h0040_0000);
    tick(10);
    check("t5_seven_beats", 32'(dut.fifo_count), 32'd7);
    pulse_start(32'h0020_0000);
    pause_beat = -1;
    tick(5);
    check("t5_drained",    32'(dut.fifo_count),  32'd0);
    n = 0;
    while (accepts < a0 + 2 && n < 60) begin
      tick(1);
      n++;
    end
    check("t5_accepts",    32'(accepts),         32'(a0 + 2));
    check("t5_new_addr",   acc_log[acc_log.size() - 1], 32'h0020_0000);

    // Underflow while the slave is slow
    tick(100);
    rsp_gap = 200;
    pulse_start(32'h0060_0000);
    tick(3);
    pix_req = 1'b1;
    tick(1);
    for (int k = 0; k < 10; k++) begin
      check("t4_pix_zero",  32'(pix_data),  32'd0);
      check("t4_underflow", 32'(underflow), 32'd1);
      tick(1);
    end
    pix_req = 1'b0;
    check("t4_pop_cnt",    32'(dut.pop_cnt_q), 32'd11);
    tick(5);
    check("t4_sticky",     32'(underflow),     32'd1);
    pulse_start(32'h0060_0000);
    rsp_gap = 0;
    tick(2);
    check("t4_cleared",    32'(underflow),     32'd0);
    tick(400);
    for (int i = 0; i < 4; i++) begin
      pix_req = 1'b1;
      @(negedge clk);
      pix_req = 1'b0;
      check("t4_new_pix", 32'(pix_data), 32'(exp_pix(32'h0060_0000, i)));
    end
    check("t4_no_uflow",   32'(underflow),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
